// File: rtl/accum_sequencer_if.sv
// Sequencer <-> datapath bundle: run control, RAM read bus and PSR flags in,
// control word, latched operand and status out.
interface accum_sequencer_if #(
    parameter int WIDTH     = 16,
    parameter int STEP_BITS = 3
);
    logic                 run;
    logic [WIDTH-1:0]     bus_in;
    logic [3:0]           flags;
    logic [14:0]          ctrl;
    logic [WIDTH-1:0]     opr_out;
    logic [STEP_BITS-1:0] step;
    logic                 halted;
    logic                 illegal;

    // Sequencer side
    modport master (
        input  run, bus_in, flags,
        output ctrl, opr_out, step, halted, illegal
    );

    // Datapath / environment side
    modport slave (
        output run, bus_in, flags,
        input  ctrl, opr_out, step, halted, illegal
    );
endinterface

// File: rtl/accum_sequencer.sv
// Microcode sequencer for the accumulator datapath. Emits one control word per
// cycle from the registered step/instruction state. Supports variable-length
// instructions, abs store, conditional jumps through an operand latch, a run
// (stall) input and halt / illegal-opcode reporting. The PC lives in RAM word 0.
module accum_sequencer #(
    parameter int WIDTH     = 16,
    parameter int STEP_BITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    accum_sequencer_if.master sif
);

    // Control word bit positions within the low 11 bits; ALU code sits in [14:11]
    localparam logic [10:0] C_AI = 11'h001;
    localparam logic [10:0] C_AS = 11'h002;
    localparam logic [10:0] C_PI = 11'h004;
    localparam logic [10:0] C_MI = 11'h010;
    localparam logic [10:0] C_RI = 11'h020;
    localparam logic [10:0] C_CN = 11'h080;
    localparam logic [10:0] C_LS = 11'h100;
    localparam logic [10:0] C_II = 11'h200;
    localparam logic [10:0] C_OS = 11'h400;

    localparam logic [3:0] L_GEN0 = 4'b0000;
    localparam logic [3:0] L_BUFB = 4'b1010;
    localparam logic [3:0] L_NEGB = 4'b0101;
    localparam logic [3:0] L_BUFA = 4'b1100;

    localparam logic [STEP_BITS-1:0] S0 = STEP_BITS'(0);
    localparam logic [STEP_BITS-1:0] S1 = STEP_BITS'(1);
    localparam logic [STEP_BITS-1:0] S2 = STEP_BITS'(2);
    localparam logic [STEP_BITS-1:0] S3 = STEP_BITS'(3);
    localparam logic [STEP_BITS-1:0] S4 = STEP_BITS'(4);
    localparam logic [STEP_BITS-1:0] S5 = STEP_BITS'(5);

    // Fetch words shared by T1 and T3 (PC += 1, MAR follows the new PC)
    localparam logic [14:0] W_FETCH0 = {L_GEN0, C_LS | C_MI};
    localparam logic [14:0] W_PCINC  = {L_BUFB, C_CN | C_LS | C_MI | C_RI};
    localparam logic [14:0] W_INST   = {L_GEN0, C_II | C_LS | C_MI};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    seq_state_t           state_q, state_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic [7:0]           inst_q, inst_d;
    logic [WIDTH-1:0]     opr_q, opr_d;
    logic                 illegal_q, illegal_d;
    logic [14:0]          ctrl_word;
    logic [14:0]          exec_word;

    // Instruction field decode (from the latched instruction byte only)
    logic [1:0] mode;
    logic [5:0] opcode;
    logic       is_imm, is_abs, is_halt;
    logic       op_nop, op_load, op_store, op_jump, op_alu;
    logic       inst_legal;
    logic       jump_taken;
    logic       unused_flags;

    assign mode     = inst_q[7:6];
    assign opcode   = inst_q[5:0];
    assign is_imm   = (mode == 2'd0);
    assign is_abs   = (mode == 2'd1);
    assign is_halt  = (inst_q == 8'hFF);
    assign op_nop   = (opcode == 6'h00);
    assign op_load  = (opcode == 6'h01);
    assign op_store = (opcode == 6'h02);
    assign op_jump  = (opcode[5:2] == 4'b0001);
    assign op_alu   = (opcode[5:2] == 4'b0010);

    // V is carried on the flag bus for the datapath but no jump tests it
    assign unused_flags = sif.flags[0];

    // Per-mode legal opcode tables, one entry per 6-bit opcode
    logic [63:0] legal_imm_mask;
    logic [63:0] legal_abs_mask;

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_legal
            // imm: nop, load, the four jumps, the four ALU ops
            assign legal_imm_mask[gi] = (gi == 0) || (gi == 1) || (gi >= 4 && gi <= 11);
            // abs: nop, load, store, the four ALU ops
            assign legal_abs_mask[gi] = (gi <= 2) || (gi >= 8 && gi <= 11);
        end
    endgenerate

    // Look up legality for the current mode; reserved modes are never legal
    always_comb begin
        inst_legal = 1'b0;
        if (is_imm) begin
            inst_legal = legal_imm_mask[opcode];
        end else if (is_abs) begin
            inst_legal = legal_abs_mask[opcode];
        end
    end

    // Jump condition selected by the low opcode bits: always, Z, C, N
    always_comb begin
        jump_taken = 1'b1;
        case (opcode[1:0])
            2'd0:    jump_taken = 1'b1;
            2'd1:    jump_taken = sif.flags[1];
            2'd2:    jump_taken = sif.flags[3];
            default: jump_taken = sif.flags[2];
        endcase
    end

    // Execute word used by imm T4 and abs T5: load, ALU ops or store
    always_comb begin
        exec_word = '0;
        if (op_load) begin
            exec_word = {L_GEN0, C_AI};
        end else if (op_alu) begin
            // opcode[1] picks subtract (NEG_B), opcode[0] adds the carry-in
            exec_word = {(opcode[1] ? L_NEGB : L_BUFB),
                         C_PI | C_AS | C_AI | (opcode[0] ? C_CN : 11'h000)};
        end else if (op_store) begin
            exec_word = {L_BUFA, C_LS | C_RI};
        end
    end

    // Raw control word for the current step; gated by reset/run/halt at the port
    always_comb begin
        ctrl_word = '0;
        if (state_q == ST_RUN) begin
            case (step_q)
                S0: ctrl_word = W_FETCH0;
                S1: ctrl_word = W_PCINC;
                S2: ctrl_word = W_INST;
                S3: ctrl_word = W_PCINC;
                S4: begin
                    if (op_jump) begin
                        // Read the jump target into the operand latch, MAR back to PC
                        ctrl_word = W_FETCH0;
                    end else if (is_abs) begin
                        // MAR <= operand (the effective address)
                        ctrl_word = {L_BUFB, C_LS | C_MI};
                    end else begin
                        ctrl_word = exec_word;
                    end
                end
                S5: begin
                    if (op_jump) begin
                        // Operand latch onto the write bus, into ram[0] (PC)
                        ctrl_word = {L_GEN0, C_OS | C_RI};
                    end else begin
                        ctrl_word = exec_word;
                    end
                end
                default: ctrl_word = '0;
            endcase
        end
    end

    // Next-state logic: step sequencing, decode at T3, operand capture at T4
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        inst_d    = inst_q;
        opr_d     = opr_q;
        illegal_d = illegal_q;

        if (sif.run && (state_q == ST_RUN)) begin
            case (step_q)
                S0, S1: step_d = step_q + S1;
                S2: begin
                    step_d = S3;
                    inst_d = sif.bus_in[7:0];
                end
                S3: begin
                    if (is_halt) begin
                        // Step parks at 3 for as long as the sequencer is halted
                        state_d = ST_HALT;
                    end else if (!inst_legal) begin
                        illegal_d = 1'b1;
                        step_d    = S0;
                    end else if (op_nop || (op_jump && !jump_taken)) begin
                        step_d = S0;
                    end else begin
                        step_d = S4;
                    end
                end
                S4: begin
                    if (op_jump) begin
                        opr_d  = sif.bus_in;
                        step_d = S5;
                    end else if (is_abs) begin
                        step_d = S5;
                    end else begin
                        step_d = S0;
                    end
                end
                default: step_d = S0;
            endcase
        end
    end

    // State registers with synchronous reset; run=0 holds via the _d defaults
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            step_q    <= S0;
            inst_q    <= 8'h00;
            opr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            inst_q    <= inst_d;
            opr_q     <= opr_d;
            illegal_q <= illegal_d;
        end
    end

    assign sif.ctrl    = (reset || !sif.run || (state_q == ST_HALT)) ? 15'h0000 : ctrl_word;
    assign sif.opr_out = opr_q;
    assign sif.step    = step_q;
    assign sif.halted  = (state_q == ST_HALT);
    assign sif.illegal = illegal_q;

endmodule
